// File: rtl/afifo_wr_arb.sv
// rtl/afifo_wr_arb.sv - round-robin write-port arbiter feeding the afifo write side
// One holding register between the granted producer and the FIFO, BURST-bounded grants.
module afifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int DWDTH = NBITS + 1,
  parameter int BURST = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NREQ-1:0]          req_vld_i,
  input  logic [NREQ*NBITS-1:0]    req_data_i,
  output logic [NREQ-1:0]          req_rdy_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_ovflw_i,
  output logic                     winc_o,
  output logic [DWDTH-1:0]         wdata_o,
  output logic [$clog2(NREQ)-1:0]  gnt_id_o,
  output logic                     busy_o,
  output logic [CNTW-1:0]          wcnt_o,
  output logic                     err_ovflw_o,
  input  logic                     clr_err_i
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_d;
  logic [IW-1:0]     ptr, ptr_d;
  logic [IW-1:0]     owner, owner_d;
  logic [BW-1:0]     beat_cnt, beat_d;
  logic              hold_vld;
  logic [NBITS-1:0]  hold_data;
  logic [CNTW-1:0]   wcnt;
  logic              err;

  logic [IW-1:0]     winner;
  logic [IW-1:0]     cand;
  logic              found;
  logic [IW-1:0]     nxt_owner;
  logic              own_vld;
  logic              own_rdy;
  logic              xfer;
  logic [NBITS-1:0]  own_data;

  // Rotating priority: first valid requester at or after ptr wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req_vld_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign nxt_owner = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign own_vld   = req_vld_i[owner];
  assign own_data  = req_data_i[owner*NBITS +: NBITS];

  assign winc_o  = hold_vld & ~fifo_full_i;
  // Full freezes the holding register, so no new word may be accepted either.
  assign own_rdy = (state == GRANT) & ~fifo_full_i & (~hold_vld | winc_o);
  assign xfer    = own_vld & own_rdy;

  always_comb begin
    req_rdy_o        = '0;
    req_rdy_o[owner] = own_rdy;
  end

  assign wdata_o     = hold_vld ? {1'b1, hold_data} : '0;
  assign gnt_id_o    = owner;
  assign busy_o      = (state == GRANT);
  assign wcnt_o      = wcnt;
  assign err_ovflw_o = err;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    beat_d  = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = winner;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_d = beat_cnt + 1'b1;
        end
        if (!own_vld || (xfer && beat_cnt == BW'(BURST - 1))) begin
          state_d = IDLE;
          ptr_d   = nxt_owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      owner    <= owner_d;
      beat_cnt <= beat_d;
    end
  end

  // A refill in the same cycle as a drain keeps hold_vld set for 1 beat/cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (xfer) begin
      hold_vld  <= 1'b1;
      hold_data <= own_data;
    end else if (winc_o) begin
      hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (winc_o) begin
        wcnt <= wcnt + 1'b1;
      end
      if (fifo_ovflw_i) begin
        err <= 1'b1;
      end else if (clr_err_i) begin
        err <= 1'b0;
      end
    end
  end

endmodule
